// File: rtl/vga_pkg.sv
// Shared VGA definitions: timing record, derived totals, colour bit-replication.
package vga_pkg;

  localparam int unsigned MAX_COLOR_BITS = 8;
  localparam int unsigned MAX_OUT_BITS   = 16;
  localparam int unsigned CIDX_W         = $clog2(MAX_COLOR_BITS);
  localparam int unsigned OIDX_W         = $clog2(MAX_OUT_BITS);

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_timing_t;

  // Total period of one axis (line or frame).
  function automatic int unsigned timing_total(input vga_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  // Replicate a cbits-wide channel MSB-first into obits, last copy truncated.
  function automatic logic [MAX_OUT_BITS-1:0] expand_color(
    input logic [MAX_COLOR_BITS-1:0] c,
    input int unsigned               cbits,
    input int unsigned               obits
  );
    logic [MAX_OUT_BITS-1:0] o;
    o = '0;
    for (int unsigned i = 0; i < MAX_OUT_BITS; i++) begin
      if (i < obits) begin
        o[OIDX_W'(obits - 1 - i)] = c[CIDX_W'(cbits - 1 - (i % cbits))];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters, phase decode and frame-start/vblank flags.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter vga_timing_t H_T = '{active: 640, fp: 16, sync: 96, bp: 48},
  parameter vga_timing_t V_T = '{active: 480, fp: 10, sync: 2, bp: 33},
  parameter int unsigned HW  = 10,
  parameter int unsigned VW  = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          h_active_c,
  output logic          v_active_c,
  output logic          hs_n_c,
  output logic          vs_n_c,
  output logic          line_end_c,
  output logic          frame_end_c,
  output logic          frame_start,
  output logic          vblank
);

  localparam logic [HW-1:0] H_LAST   = HW'(timing_total(H_T) - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_T.active);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_T.active + H_T.fp);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_T.active + H_T.fp + H_T.sync);
  localparam logic [VW-1:0] V_LAST   = VW'(timing_total(V_T) - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_T.active);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_T.active + V_T.fp);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_T.active + V_T.fp + V_T.sync);

  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;

  // Next counter values and phase decode of the current position.
  always_comb begin
    line_end_c  = (h_cnt == H_LAST);
    frame_end_c = line_end_c && (v_cnt == V_LAST);
    h_nxt       = line_end_c ? '0 : h_cnt + HW'(1);
    v_nxt       = v_cnt;
    if (line_end_c) begin
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end
    h_active_c = (h_cnt < H_ACT);
    v_active_c = (v_cnt < V_ACT);
    hs_n_c     = !((h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E));
    vs_n_c     = !((v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E));
  end

  // Counters plus flags computed from next values so they align with the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      frame_start <= (v_nxt == V_ACT) && (h_nxt == '0);
      vblank      <= (v_nxt >= V_ACT);
    end
  end

endmodule

// File: rtl/vga_fb_scanout.sv
// VGA scanout: timing, scaled frame-buffer walk, colour expansion, DAC drive.
// Optional page flipping is enabled by defining VGA_PAGE_FLIP_EN.
module vga_fb_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned SCALE_LOG2 = 4,
  parameter int unsigned FB_W       = 40,
  parameter int unsigned FB_H       = 30,
  parameter int unsigned COLOR_BITS = 2,
  parameter int unsigned OUT_BITS   = 10,
`ifdef VGA_PAGE_FLIP_EN
  parameter int unsigned FB_ADDR_WIDTH = 12
`else
  parameter int unsigned FB_ADDR_WIDTH = 11
`endif
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
`ifdef VGA_PAGE_FLIP_EN
  input  logic                     iPage_Sel,
  output logic                     oPage_Active,
`endif
  output logic [FB_ADDR_WIDTH-1:0] oFB_Addr,
  input  logic [3*COLOR_BITS-1:0]  iFB_Data,
  input  logic [3*COLOR_BITS-1:0]  iBorder_RGB,
  output logic [OUT_BITS-1:0]      oVGA_R,
  output logic [OUT_BITS-1:0]      oVGA_G,
  output logic [OUT_BITS-1:0]      oVGA_B,
  output logic                     oVGA_H_SYNC,
  output logic                     oVGA_V_SYNC,
  output logic                     oVGA_BLANK,
  output logic                     oVGA_SYNC,
  output logic                     oVGA_CLOCK,
  output logic                     oFrame_Start,
  output logic                     oVblank
);

  localparam vga_timing_t H_T = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam vga_timing_t V_T = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  localparam int unsigned HW  = $clog2(timing_total(H_T) + 1);
  localparam int unsigned VW  = $clog2(timing_total(V_T) + 1);
`ifdef VGA_PAGE_FLIP_EN
  localparam int unsigned PAW = FB_ADDR_WIDTH - 1;
`else
  localparam int unsigned PAW = FB_ADDR_WIDTH;
`endif
  localparam logic [HW-1:0] FB_W_H   = HW'(FB_W);
  localparam logic [VW-1:0] FB_H_V   = VW'(FB_H);
  localparam logic [VW-1:0] SUB_MASK = VW'((1 << SCALE_LOG2) - 1);

  logic [HW-1:0]  h_cnt, col_c;
  logic [VW-1:0]  v_cnt, v_row_c;
  logic           h_active_c, v_active_c, hs_n_c, vs_n_c, line_end_c, frame_end_c;
  logic           in_fb_c;
  logic [PAW-1:0] row_base, addr_c;
  logic           s1_active, s1_in_fb, s1_hs_n, s1_vs_n;
  logic           s2_active, s2_in_fb, s2_hs_n, s2_vs_n;
  logic [3*COLOR_BITS-1:0] pix_c;

  vga_timing_gen #(.H_T(H_T), .V_T(V_T), .HW(HW), .VW(VW)) u_timing (
    .clk         (iCLK),
    .rst_n       (iRST_N),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .h_active_c  (h_active_c),
    .v_active_c  (v_active_c),
    .hs_n_c      (hs_n_c),
    .vs_n_c      (vs_n_c),
    .line_end_c  (line_end_c),
    .frame_end_c (frame_end_c),
    .frame_start (oFrame_Start),
    .vblank      (oVblank)
  );

  assign oVGA_SYNC  = 1'b0;
  assign oVGA_CLOCK = ~iCLK;

  // Buffer cell under the beam and its address.
  always_comb begin
    col_c   = h_cnt >> SCALE_LOG2;
    v_row_c = v_cnt >> SCALE_LOG2;
    in_fb_c = h_active_c && v_active_c && (col_c < FB_W_H) && (v_row_c < FB_H_V);
    addr_c  = row_base + PAW'(col_c);
  end

  // Row base steps by one buffer row after the last screen line of each scaled row.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      row_base <= '0;
    end else if (frame_end_c) begin
      row_base <= '0;
    end else if (line_end_c && ((v_cnt & SUB_MASK) == SUB_MASK) && (v_row_c < FB_H_V)) begin
      row_base <= row_base + PAW'(FB_W);
    end
  end

`ifdef VGA_PAGE_FLIP_EN
  logic page_q;

  // Displayed page only changes at the frame-start strobe.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      page_q <= 1'b0;
    end else if (oFrame_Start) begin
      page_q <= iPage_Sel;
    end
  end

  assign oPage_Active = page_q;
`endif

  // Stage 1: address register (held outside the buffer area) and flag delay.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oFB_Addr  <= '0;
      s1_active <= 1'b0;
      s1_in_fb  <= 1'b0;
      s1_hs_n   <= 1'b1;
      s1_vs_n   <= 1'b1;
    end else begin
      if (in_fb_c) begin
`ifdef VGA_PAGE_FLIP_EN
        oFB_Addr <= {page_q, addr_c};
`else
        oFB_Addr <= addr_c;
`endif
      end
      s1_active <= h_active_c && v_active_c;
      s1_in_fb  <= in_fb_c;
      s1_hs_n   <= hs_n_c;
      s1_vs_n   <= vs_n_c;
    end
  end

  // Stage 2: flags wait for the buffer read data.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s2_active <= 1'b0;
      s2_in_fb  <= 1'b0;
      s2_hs_n   <= 1'b1;
      s2_vs_n   <= 1'b1;
    end else begin
      s2_active <= s1_active;
      s2_in_fb  <= s1_in_fb;
      s2_hs_n   <= s1_hs_n;
      s2_vs_n   <= s1_vs_n;
    end
  end

  // Colour select: black in blanking, buffer word inside, border outside.
  always_comb begin
    pix_c = '0;
    if (s2_active) begin
      pix_c = s2_in_fb ? iFB_Data : iBorder_RGB;
    end
  end

  // Stage 3: DAC pins and syncs registered together.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVGA_R      <= '0;
      oVGA_G      <= '0;
      oVGA_B      <= '0;
      oVGA_BLANK  <= 1'b0;
      oVGA_H_SYNC <= 1'b1;
      oVGA_V_SYNC <= 1'b1;
    end else begin
      oVGA_R      <= OUT_BITS'(expand_color(MAX_COLOR_BITS'(pix_c[3*COLOR_BITS-1:2*COLOR_BITS]),
                                            COLOR_BITS, OUT_BITS));
      oVGA_G      <= OUT_BITS'(expand_color(MAX_COLOR_BITS'(pix_c[2*COLOR_BITS-1:COLOR_BITS]),
                                            COLOR_BITS, OUT_BITS));
      oVGA_B      <= OUT_BITS'(expand_color(MAX_COLOR_BITS'(pix_c[COLOR_BITS-1:0]),
                                            COLOR_BITS, OUT_BITS));
      oVGA_BLANK  <= s2_active;
      oVGA_H_SYNC <= s2_hs_n;
      oVGA_V_SYNC <= s2_vs_n;
    end
  end

endmodule
